// File: rtl/sap2_reg_bank.sv
// sap2_reg_bank: W-bus register bank with INR/DCR flags and a two-cycle exchange; SAP2_REG_BYPASS_EN adds ALU write-through
module sap2_reg_bank #(
   parameter int WIDTH   = 8,
   parameter int NREGS   = 3,
   parameter int ALU_IDX = 0,
   parameter int SELW    = 2
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [WIDTH-1:0] iData,
   input  logic             iLoad,
   input  logic [SELW-1:0]  iLoadSel,
   input  logic             iEn,
   input  logic [SELW-1:0]  iEnSel,
   input  logic             iIncr,
   input  logic             iDecr,
   input  logic [SELW-1:0]  iOpSel,
   input  logic             iSwap,
   input  logic [SELW-1:0]  iSwapA,
   input  logic [SELW-1:0]  iSwapB,
   output logic [WIDTH-1:0] oALU,
   output logic [WIDTH-1:0] wBus,
   output logic             oZero,
   output logic             oSign,
   output logic             oBusy
);
   localparam logic       IDLE = 1'b0;
   localparam logic       XCH  = 1'b1;
   localparam logic [SELW:0] N = NREGS[SELW:0];
   logic [WIDTH-1:0] r_regs [NREGS];
   logic [WIDTH-1:0] r_hold;
   logic [SELW-1:0]  r_bsel;
   logic             r_state;
   logic             r_zero;
   logic             r_sign;
   logic             w_ld_ok;
   logic             w_op_ok;
   logic             w_sw_ok;
   logic             w_en_ok;
   logic             w_ld_do;
   logic             w_op_do;
   logic [WIDTH-1:0] w_op_val;
   logic [WIDTH-1:0] w_rd;
   assign w_ld_ok  = iLoad && ({1'b0, iLoadSel} < N);
   assign w_op_ok  = (iIncr ^ iDecr) && ({1'b0, iOpSel} < N);
   assign w_sw_ok  = iSwap && (iSwapA != iSwapB) && ({1'b0, iSwapA} < N) && ({1'b0, iSwapB} < N);
   assign w_en_ok  = {1'b0, iEnSel} < N;
   assign w_ld_do  = (r_state == IDLE) && !w_sw_ok && w_ld_ok;
   // a load to the same index wins over INR/DCR; different indices both execute
   assign w_op_do  = (r_state == IDLE) && !w_sw_ok && w_op_ok && !(w_ld_ok && iLoadSel == iOpSel);
   assign w_op_val = iIncr ? r_regs[iOpSel] + WIDTH'(1) : r_regs[iOpSel] - WIDTH'(1);
   assign w_rd     = w_en_ok ? r_regs[iEnSel] : '0;
   assign wBus     = (iEn && !iRst) ? w_rd : 'z;
   assign oZero    = r_zero;
   assign oSign    = r_sign;
   assign oBusy    = r_state == XCH;
`ifdef SAP2_REG_BYPASS_EN
   assign oALU = (w_ld_do && iLoadSel == SELW'(ALU_IDX)) ? iData : r_regs[ALU_IDX];
`else
   assign oALU = r_regs[ALU_IDX];
`endif
   always_ff @(posedge iClk) begin
      if (iRst) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_hold  <= '0;
         r_bsel  <= '0;
         r_state <= IDLE;
         r_zero  <= 1'b0;
         r_sign  <= 1'b0;
      end else if (r_state == XCH) begin
         r_regs[r_bsel] <= r_hold;
         r_state        <= IDLE;
      end else if (w_sw_ok) begin
         r_hold         <= r_regs[iSwapA];
         r_regs[iSwapA] <= r_regs[iSwapB];
         r_bsel         <= iSwapB;
         r_state        <= XCH;
      end else begin
         if (w_ld_do) r_regs[iLoadSel] <= iData;
         if (w_op_do) begin
            r_regs[iOpSel] <= w_op_val;
            r_zero         <= w_op_val == '0;
            r_sign         <= w_op_val[WIDTH-1];
         end
      end
   end
endmodule
